// File: rtl/branch_resolution_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolution_unit_pkg
//   Shared types for the branch resolution unit: the PC width macro, the
//   prediction record kept per in-flight instruction, the resolution FSM
//   state type and a wrapping PC increment helper.
//   Ports: none (package).
// -----------------------------------------------------------------------------
`ifndef PC_SIZE
`define PC_SIZE 8
`endif

package branch_resolution_unit_pkg;

  localparam int PC_W = `PC_SIZE;

  typedef logic [PC_W-1:0] pc_t;

  // One prediction record as pushed by fetch.
  typedef struct packed {
    pc_t  pc;
    logic pred_taken;
    pc_t  pred_target;
  } bru_entry_t;

  typedef enum logic {
    BRU_ACTIVE  = 1'b0,
    BRU_RECOVER = 1'b1
  } bru_state_t;

  // Fall-through PC; wraps naturally at PC_W bits.
  function automatic pc_t pc_next(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/branch_resolution_unit_if.sv
// -----------------------------------------------------------------------------
// branch_feedback_ifc
//   Feedback bundle from the branch resolution unit to the BTB update port.
//   Signals:
//     pc              - PC of the resolved instruction
//     branch          - actual taken outcome
//     feedback_target - correct next PC for that instruction
//   Modports: master (driver, the resolution unit), slave (BTB side).
// -----------------------------------------------------------------------------
`ifndef PC_SIZE
`define PC_SIZE 8
`endif

interface branch_feedback_ifc;
  import branch_resolution_unit_pkg::*;

  pc_t  pc;
  logic branch;
  pc_t  feedback_target;

  modport master (output pc, output branch, output feedback_target);
  modport slave  (input  pc, input  branch, input  feedback_target);
endinterface

// File: rtl/branch_resolution_unit_pred_queue.sv
// -----------------------------------------------------------------------------
// bru_pred_queue
//   In-order circular buffer of prediction records.
//   Ports:
//     clk, n_rst      - clock, asynchronous active-low reset
//     push/push_entry - append one record (ignored when full)
//     pop             - drop the oldest record (ignored when empty)
//     clear           - flush everything; wins over push and pop
//     head_entry      - oldest record (combinational read)
//     count/full/empty- occupancy status
// -----------------------------------------------------------------------------
`ifndef PC_SIZE
`define PC_SIZE 8
`endif

module bru_pred_queue
  import branch_resolution_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  bru_entry_t                 push_entry,
  input  logic                       pop,
  input  logic                       clear,
  output bru_entry_t                 head_entry,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  bru_entry_t       mem_q [DEPTH];
  bru_entry_t       mem_d [DEPTH];

  logic do_push;
  logic do_pop;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign head_entry = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer, occupancy and storage update. DEPTH is a power of two, so the
  // pointers wrap for free at PTR_W bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// -----------------------------------------------------------------------------
// branch_resolution_unit
//   Holds fetch-time predictions in order, compares the oldest one against the
//   execute-stage outcome, emits BTB feedback and a one-cycle mispredict
//   redirect to fetch.
//   Ports:
//     clk, n_rst                     - clock, asynchronous active-low reset
//     pred_valid/pc/taken/target     - prediction push from fetch
//     pred_ready                     - push accepted this cycle
//     res_valid/is_branch/taken/target - resolution of the oldest instruction
//     feedback_valid, o_feedback     - registered BTB feedback
//     mispredict, redirect_pc        - registered redirect pulse
//     underflow_err                  - sticky: resolution with empty queue
//   Optional: define BRU_STATS_EN to add stat_branches / stat_mispredicts,
//   16-bit saturating event counters.
// -----------------------------------------------------------------------------
`ifndef PC_SIZE
`define PC_SIZE 8
`endif

module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 pred_valid,
  input  logic [`PC_SIZE-1:0]  pred_pc,
  input  logic                 pred_taken,
  input  logic [`PC_SIZE-1:0]  pred_target,
  output logic                 pred_ready,
  input  logic                 res_valid,
  input  logic                 res_is_branch,
  input  logic                 res_taken,
  input  logic [`PC_SIZE-1:0]  res_target,
  output logic                 feedback_valid,
  branch_feedback_ifc.master   o_feedback,
  output logic                 mispredict,
  output logic [`PC_SIZE-1:0]  redirect_pc,
  output logic                 underflow_err
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]          stat_branches,
  output logic [15:0]          stat_mispredicts
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  bru_state_t state_q, state_d;

  bru_entry_t       head_entry;
  bru_entry_t       push_entry;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;

  logic active;
  logic pop_fire;
  logic push_fire;
  logic mismatch;
  logic mis_fire;
  logic fb_fire;
  logic underflow_fire;
  pc_t  correct_pc;

  logic feedback_valid_q, feedback_valid_d;
  pc_t  fb_pc_q, fb_pc_d;
  logic fb_branch_q, fb_branch_d;
  pc_t  fb_target_q, fb_target_d;
  logic mispredict_q, mispredict_d;
  pc_t  redirect_pc_q, redirect_pc_d;
  logic underflow_q, underflow_d;

  assign active = (state_q == BRU_ACTIVE);

  // Reset gates ready directly so fetch never sees a stale accept while held.
  assign pred_ready = n_rst && active && !q_full;

  assign pop_fire       = active && res_valid && (q_count != '0);
  assign underflow_fire = active && res_valid && q_empty;

  assign mismatch = (head_entry.pred_taken != res_taken) ||
                    (res_taken && (head_entry.pred_target != res_target));
  assign mis_fire = pop_fire && mismatch;

  // Non-branches that were predicted taken still produce feedback so the BTB
  // can evict the stale entry.
  assign fb_fire    = pop_fire && (res_is_branch || head_entry.pred_taken);
  assign correct_pc = res_taken ? res_target : pc_next(head_entry.pc);

  // A push colliding with a mismatching pop belongs to the wrong path.
  assign push_fire  = pred_valid && pred_ready && !mis_fire;

  assign push_entry = '{pc: pred_pc, pred_taken: pred_taken, pred_target: pred_target};

  bru_pred_queue #(
    .DEPTH (DEPTH)
  ) u_pred_queue (
    .clk        (clk),
    .n_rst      (n_rst),
    .push       (push_fire),
    .push_entry (push_entry),
    .pop        (pop_fire),
    .clear      (mis_fire),
    .head_entry (head_entry),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  // Recovery lasts exactly one cycle; the queue flush happens on entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BRU_ACTIVE:  if (mis_fire) state_d = BRU_RECOVER;
      BRU_RECOVER: state_d = BRU_ACTIVE;
      default:     state_d = BRU_ACTIVE;
    endcase
  end

  // Output register next values. Payload fields hold between events; only
  // the valid/pulse bits are one-cycle.
  always_comb begin
    feedback_valid_d = fb_fire;
    fb_pc_d          = fb_pc_q;
    fb_branch_d      = fb_branch_q;
    fb_target_d      = fb_target_q;
    mispredict_d     = mis_fire;
    redirect_pc_d    = redirect_pc_q;
    underflow_d      = underflow_q || underflow_fire;
    if (fb_fire) begin
      fb_pc_d     = head_entry.pc;
      fb_branch_d = res_taken;
      fb_target_d = correct_pc;
    end
    if (mis_fire) begin
      redirect_pc_d = correct_pc;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q          <= BRU_ACTIVE;
      feedback_valid_q <= 1'b0;
      fb_pc_q          <= '0;
      fb_branch_q      <= 1'b0;
      fb_target_q      <= '0;
      mispredict_q     <= 1'b0;
      redirect_pc_q    <= '0;
      underflow_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      feedback_valid_q <= feedback_valid_d;
      fb_pc_q          <= fb_pc_d;
      fb_branch_q      <= fb_branch_d;
      fb_target_q      <= fb_target_d;
      mispredict_q     <= mispredict_d;
      redirect_pc_q    <= redirect_pc_d;
      underflow_q      <= underflow_d;
    end
  end

  assign feedback_valid             = feedback_valid_q;
  assign o_feedback.pc              = fb_pc_q;
  assign o_feedback.branch          = fb_branch_q;
  assign o_feedback.feedback_target = fb_target_q;
  assign mispredict                 = mispredict_q;
  assign redirect_pc                = redirect_pc_q;
  assign underflow_err              = underflow_q;

`ifdef BRU_STATS_EN
  logic [15:0] stat_br_q, stat_br_d;
  logic [15:0] stat_mis_q, stat_mis_d;

  // Saturating event counters, advanced alongside the registered outputs.
  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (fb_fire && (stat_br_q != 16'hFFFF)) begin
      stat_br_d = stat_br_q + 16'd1;
    end
    if (mis_fire && (stat_mis_q != 16'hFFFF)) begin
      stat_mis_d = stat_mis_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolution_unit
//   Directed and randomized stimulus for branch_resolution_unit, checked each
//   cycle against a queue-based reference model of the prediction tracking.
// -----------------------------------------------------------------------------
`ifndef PC_SIZE
`define PC_SIZE 8
`endif

module tb_branch_resolution_unit;
  import branch_resolution_unit_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = `PC_SIZE;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          pred_valid;
  logic [PW-1:0] pred_pc;
  logic          pred_taken;
  logic [PW-1:0] pred_target;
  logic          pred_ready;
  logic          res_valid;
  logic          res_is_branch;
  logic          res_taken;
  logic [PW-1:0] res_target;
  logic          feedback_valid;
  logic          mispredict;
  logic [PW-1:0] redirect_pc;
  logic          underflow_err;

  branch_feedback_ifc fb_if ();

  branch_resolution_unit #(
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_ready     (pred_ready),
    .res_valid      (res_valid),
    .res_is_branch  (res_is_branch),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .feedback_valid (feedback_valid),
    .o_feedback     (fb_if.master),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  // Reference model state: the in-flight predictions as a plain queue.
  typedef struct {
    logic [PW-1:0] pc;
    bit            taken;
    logic [PW-1:0] tgt;
  } rec_t;

  rec_t          mq[$];
  bit            m_recover;
  bit            m_underflow;
  bit            exp_fbv;
  bit            exp_mis;
  logic [PW-1:0] exp_pc;
  bit            exp_branch;
  logic [PW-1:0] exp_tgt;
  logic [PW-1:0] exp_redir;

  int passed = 0;
  int total  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic modelStep(input bit pv, input logic [PW-1:0] ppc, input bit pt,
                           input logic [PW-1:0] ptg, input bit rv, input bit rb,
                           input bit rt, input logic [PW-1:0] rtg);
    bit            rdy;
    bit            wrong;
    rec_t          e;
    rec_t          n;
    logic [PW-1:0] correct_next;
    rdy     = !m_recover && (mq.size() < DEPTH);
    exp_fbv = 0;
    exp_mis = 0;
    if (m_recover) begin
      m_recover = 0;
    end else begin
      if (rv && mq.size() == 0) m_underflow = 1;
      if (rv && mq.size() > 0) begin
        e            = mq.pop_front();
        wrong        = (e.taken != rt) || (rt && e.tgt != rtg);
        correct_next = rt ? rtg : PW'(e.pc + 1);
        if (rb || e.taken) begin
          exp_fbv    = 1;
          exp_pc     = e.pc;
          exp_branch = rt;
          exp_tgt    = correct_next;
        end
        if (wrong) begin
          exp_mis   = 1;
          exp_redir = correct_next;
          mq.delete();
          m_recover = 1;
          rdy       = 0;
        end
      end
      if (pv && rdy) begin
        n.pc    = ppc;
        n.taken = pt;
        n.tgt   = ptg;
        mq.push_back(n);
      end
    end
  endtask

  // Drive one cycle of inputs, step the model, then compare after the edge.
  task automatic applyStimulus(input bit pv, input logic [PW-1:0] ppc, input bit pt,
                               input logic [PW-1:0] ptg, input bit rv, input bit rb,
                               input bit rt, input logic [PW-1:0] rtg);
    pred_valid    = pv;
    pred_pc       = ppc;
    pred_taken    = pt;
    pred_target   = ptg;
    res_valid     = rv;
    res_is_branch = rb;
    res_taken     = rt;
    res_target    = rtg;
    modelStep(pv, ppc, pt, ptg, rv, rb, rt, rtg);
    @(posedge clk);
    #1;
    checkOutput("pred_ready", pred_ready, !m_recover && (mq.size() < DEPTH));
    checkOutput("feedback_valid", feedback_valid, exp_fbv);
    checkOutput("mispredict", mispredict, exp_mis);
    checkOutput("underflow_err", underflow_err, m_underflow);
    if (exp_fbv) begin
      checkOutput("fb_pc", fb_if.pc, exp_pc);
      checkOutput("fb_branch", fb_if.branch, exp_branch);
      checkOutput("fb_target", fb_if.feedback_target, exp_tgt);
    end
    if (exp_mis) begin
      checkOutput("redirect_pc", redirect_pc, exp_redir);
    end
  endtask

  task automatic doPush(input logic [PW-1:0] pc, input bit pt, input logic [PW-1:0] tg);
    applyStimulus(1, pc, pt, tg, 0, 0, 0, '0);
  endtask

  task automatic doRes(input bit rb, input bit rt, input logic [PW-1:0] tg);
    applyStimulus(0, '0, 0, '0, 1, rb, rt, tg);
  endtask

  task automatic doIdle();
    applyStimulus(0, '0, 0, '0, 0, 0, 0, '0);
  endtask

  task automatic checkAllZero(input string where);
    checkOutput({where, "_pred_ready"}, pred_ready, 0);
    checkOutput({where, "_feedback_valid"}, feedback_valid, 0);
    checkOutput({where, "_fb_pc"}, fb_if.pc, 0);
    checkOutput({where, "_fb_branch"}, fb_if.branch, 0);
    checkOutput({where, "_fb_target"}, fb_if.feedback_target, 0);
    checkOutput({where, "_mispredict"}, mispredict, 0);
    checkOutput({where, "_redirect_pc"}, redirect_pc, 0);
    checkOutput({where, "_underflow_err"}, underflow_err, 0);
  endtask

  task automatic modelReset();
    mq.delete();
    m_recover   = 0;
    m_underflow = 0;
    exp_fbv     = 0;
    exp_mis     = 0;
  endtask

  initial begin
    bit            pv, pt, rv, rb, rt;
    logic [PW-1:0] ppc, ptg, rtg;

    n_rst         = 1'b0;
    pred_valid    = 1'b0;
    pred_pc       = '0;
    pred_taken    = 1'b0;
    pred_target   = '0;
    res_valid     = 1'b0;
    res_is_branch = 1'b0;
    res_taken     = 1'b0;
    res_target    = '0;
    modelReset();

    // Reset state.
    #12;
    checkAllZero("reset");
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_ready", pred_ready, 1);
    $display("[TB] reset released");

    // Not-taken non-branch: no feedback, no redirect.
    doPush(8'h10, 0, 8'h00);
    doRes(0, 0, 8'h00);

    // Correctly predicted taken branch.
    doPush(8'h20, 1, 8'h40);
    doRes(1, 1, 8'h40);

    // Mispredicted not-taken: flush of younger entries, one recovery cycle.
    doPush(8'h30, 0, 8'h00);
    doPush(8'h31, 0, 8'h00);
    doPush(8'h32, 0, 8'h00);
    doRes(1, 1, 8'h50);
    doIdle();

    // Fill to DEPTH, then a push colliding with a pop while full is refused.
    for (int i = 0; i < DEPTH; i++) doPush(PW'(8'h60 + i), 0, 8'h00);
    applyStimulus(1, 8'h64, 0, 8'h00, 1, 0, 0, 8'h00);
    doPush(8'h65, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) doRes(0, 0, 8'h00);

    // Predicted taken but not taken at the top of the PC space.
    doPush(8'hFF, 1, 8'h80);
    doRes(1, 0, 8'h00);

    // Resolution during recovery is ignored; then an empty-queue resolution.
    doRes(1, 1, 8'h12);
    doRes(1, 1, 8'h12);
    doIdle();
    doIdle();

    // Randomized traffic; most resolutions agree with the oldest prediction.
    $display("[TB] random phase");
    for (int c = 0; c < 400; c++) begin
      pv  = 1'($urandom_range(0, 1));
      ppc = PW'($urandom_range(0, 255));
      pt  = ($urandom_range(0, 2) == 0);
      ptg = PW'($urandom_range(0, 255));
      rv  = ($urandom_range(0, 2) != 0);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
        rt  = mq[0].taken;
        rtg = mq[0].tgt;
        rb  = rt ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        rt  = 1'($urandom_range(0, 1));
        rb  = rt ? 1'b1 : 1'($urandom_range(0, 1));
        rtg = PW'($urandom_range(0, 255));
      end
      applyStimulus(pv, ppc, pt, ptg, rv, rb, rt, rtg);
    end

    // Reset asserted right after a feedback pulse appears.
    doIdle();
    doIdle();
    doPush(8'h70, 1, 8'h90);
    doRes(1, 1, 8'h90);
    #2;
    n_rst = 1'b0;
    #1;
    checkAllZero("midreset");
    modelReset();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    doIdle();
    doPush(8'h11, 1, 8'h22);
    doRes(1, 1, 8'h22);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against an unexpected stall of the directed sequence.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
